// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: classifies each fetched instruction for the immediate
// extender and buffers up to two beats (output + skid register) behind a valid/ready handshake.
module imm_decode_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_immsrc,
  output logic             out_uses_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  immsrc;
    logic        uses_imm;
    logic        illegal;
  } beat_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  beat_t            in_beat;
  beat_t            out_reg, out_next;
  beat_t            skid_reg, skid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             accept, consume;

  // Decode happens at the input so the class travels with the instruction word.
  always_comb begin
    in_beat.instr    = in_instr;
    in_beat.immsrc   = 2'b00;
    in_beat.uses_imm = 1'b0;
    in_beat.illegal  = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: in_beat.uses_imm = 1'b1;
      7'b0100011: begin
        in_beat.immsrc   = 2'b01;
        in_beat.uses_imm = 1'b1;
      end
      7'b1100011: in_beat.immsrc = 2'b10;
      7'b1101111: begin
        in_beat.immsrc   = 2'b11;
        in_beat.uses_imm = 1'b1;
      end
      7'b0110011: in_beat.uses_imm = 1'b0;
      default:    in_beat.illegal  = 1'b1;
    endcase
  end

  assign in_ready  = (state_reg != ST_TWO);
  assign out_valid = (state_reg != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            out_next   = in_beat;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            out_next = in_beat;
          end else if (accept) begin
            skid_next  = in_beat;
            state_next = ST_TWO;
          end else if (consume) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            out_next   = skid_reg;
            state_next = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // A consume in a flush cycle is still a delivery, so counting ignores flush.
  always_comb begin
    cnt_next = cnt_reg;
    if (consume && out_reg.illegal && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      skid_reg  <= skid_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign out_instr    = out_reg.instr;
  assign out_immsrc   = out_reg.immsrc;
  assign out_uses_imm = out_reg.uses_imm;
  assign out_illegal  = out_reg.illegal;
  assign illegal_cnt  = cnt_reg;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed bench for imm_decode_ctrl: decode table, backpressure, illegal
// counting with saturation, flush, async reset and back-to-back streaming.
module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_immsrc;
  logic        out_uses_imm;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  imm_decode_ctrl #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_immsrc   (out_immsrc),
    .out_uses_imm (out_uses_imm),
    .out_illegal  (out_illegal),
    .illegal_cnt  (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat with out_ready=1 and check it one edge later.
  // dec = {immsrc, uses_imm, illegal}
  task automatic send_check(input string tag, input logic [31:0] instr, input logic [3:0] dec);
    in_valid = 1'b1;
    in_instr = instr;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    $display("xfer %s instr=%h immsrc=%b uses_imm=%b illegal=%b", tag, out_instr,
             out_immsrc, out_uses_imm, out_illegal);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".instr"}, out_instr, instr);
    check({tag, ".dec"}, 32'({out_immsrc, out_uses_imm, out_illegal}), 32'(dec));
  endtask

  logic [31:0] strm_instr [10];
  logic [3:0]  strm_dec   [10];

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    #2;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_instr", out_instr, 32'd0);
    check("rst.dec", 32'({out_immsrc, out_uses_imm, out_illegal}), 32'd0);
    check("rst.cnt", 32'(illegal_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Decode table, streaming with out_ready held high
    out_ready = 1'b1;
    send_check("addi", 32'h00500093, 4'b0010);
    send_check("sw",   32'h00112223, 4'b0110);
    send_check("beq",  32'h00208463, 4'b1000);
    send_check("jal",  32'h008000EF, 4'b1110);
    send_check("add",  32'h002081B3, 4'b0000);
    send_check("lw",   32'h00002003, 4'b0010);
    send_check("jalr", 32'h000080E7, 4'b0010);
    in_valid = 1'b0;
    step();
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: two accepted, third held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100113;
    step();
    check("bp.a.instr", out_instr, 32'h00100113);
    check("bp.a.in_ready", 32'(in_ready), 32'd1);
    in_instr = 32'h00412023;
    step();
    check("bp.b.in_ready", 32'(in_ready), 32'd0);
    check("bp.b.hold", out_instr, 32'h00100113);
    in_instr = 32'h00000463;
    step();
    check("bp.c.in_ready", 32'(in_ready), 32'd0);
    check("bp.c.hold", out_instr, 32'h00100113);
    check("bp.c.hold_dec", 32'({out_immsrc, out_uses_imm, out_illegal}), 32'b0010);
    out_ready = 1'b1;
    step();
    $display("xfer bp instr=%h", out_instr);
    check("bp.rel1.instr", out_instr, 32'h00412023);
    check("bp.rel1.dec", 32'(out_immsrc), 32'd1);
    check("bp.rel1.in_ready", 32'(in_ready), 32'd1);
    step();
    $display("xfer bp instr=%h", out_instr);
    check("bp.rel2.instr", out_instr, 32'h00000463);
    check("bp.rel2.valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("bp.empty", 32'(out_valid), 32'd0);

    // Illegal counting
    send_check("lui", 32'h000002B7, 4'b0001);
    send_check("op7f", 32'h0000007F, 4'b0001);
    in_valid = 1'b0;
    step();
    check("ill.cnt2", 32'(illegal_cnt), 32'd2);

    // Flush from TWO: buffered illegal beat dropped, counter unchanged
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00000037;
    step();
    in_instr = 32'h00000017;
    step();
    check("fl.two", 32'(in_ready), 32'd0);
    in_instr = 32'h00000093;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check("fl.out_valid", 32'(out_valid), 32'd0);
    check("fl.in_ready", 32'(in_ready), 32'd1);
    check("fl.cnt", 32'(illegal_cnt), 32'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("fl.no_deliver", 32'(out_valid), 32'd0);
    check("fl.cnt2", 32'(illegal_cnt), 32'd2);
    send_check("fl.after", 32'h00A00513, 4'b0010);
    in_valid = 1'b0;
    step();

    // Saturation: 300 illegal beats streamed
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_instr = {i[24:0], 7'b0110111};
      if (i == 100) check("sat.mid", 32'(illegal_cnt), 32'd101);
      step();
    end
    in_valid = 1'b0;
    step();
    check("sat.cnt", 32'(illegal_cnt), 32'd255);
    step();
    check("sat.hold", 32'(illegal_cnt), 32'd255);

    // Async reset while in ONE
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00300193;
    step();
    check("ar.one", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'd0);
    check("ar.in_ready", 32'(in_ready), 32'd1);
    check("ar.cnt", 32'(illegal_cnt), 32'd0);
    check("ar.instr", out_instr, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    send_check("ar.jal", 32'h010000EF, 4'b1110);
    in_valid = 1'b0;
    step();

    // Ten cycles of simultaneous accept and consume in ONE
    strm_instr = '{32'h00108093, 32'h00512423, 32'h00B50463, 32'h00C000EF, 32'h40B50533,
                   32'h0000A083, 32'h00058067, 32'h12345037, 32'h00000073, 32'hFFF10113};
    strm_dec   = '{4'b0010, 4'b0110, 4'b1000, 4'b1110, 4'b0000,
                   4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010};
    for (int i = 0; i < 10; i++) begin
      send_check($sformatf("strm%0d", i), strm_instr[i], strm_dec[i]);
    end
    in_valid = 1'b0;
    step();
    check("strm.empty", 32'(out_valid), 32'd0);
    check("strm.cnt", 32'(illegal_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
